// File: rtl/discrete_audio_pkg.sv
// rtl/discrete_audio_pkg.sv - shared sample types, filter states and coefficient helper for the discrete-audio chain
package discrete_audio_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [17:0] sum_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } filt_state_t;

    // alpha = RC/(RC+dt) as unsigned Q0.16; dt is one sample period in Q32 seconds
    function automatic logic [15:0] calc_alpha(input longint sample_rate,
                                               input longint r,
                                               input longint c_35_shifted);
        longint dt;
        longint rc;
        dt = (64'sd1 <<< 32) / sample_rate;
        rc = (r * c_35_shifted) >>> 3;
        return 16'((rc <<< 16) / (rc + dt));
    endfunction

endpackage

// File: rtl/serial_mult_16.sv
// rtl/serial_mult_16.sv - bit-serial shift-add multiplier, 18-bit signed x 16-bit unsigned, 34-bit product
module serial_mult_16
    import discrete_audio_pkg::*;
(
    input  logic               clk,
    input  logic               I_RST,
    input  logic               start,
    input  sum_t               mcand,
    input  logic [15:0]        mplier,
    output logic               done,
    output logic signed [33:0] product
);

    logic signed [33:0] mcand_r;
    logic [15:0]        mplier_r;
    logic [3:0]         count;
    logic               running;

    // done marks the cycle of the final add; product is complete after that edge
    assign done = running && (count == 4'd15);

    always_ff @(posedge clk) begin
        if (I_RST) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            product  <= '0;
            count    <= '0;
            running  <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{16{mcand[17]}}, mcand};
            mplier_r <= mplier;
            product  <= '0;
            count    <= '0;
            running  <= 1'b1;
        end else if (running) begin
            if (mplier_r[count])
                product <= product + (mcand_r <<< count);
            count <= count + 4'd1;
            if (count == 4'd15)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/rc_high_pass_filter_serial.sv
// rtl/rc_high_pass_filter_serial.sv - first-order RC high-pass, serial multiply; RC_HPF_SATURATE_EN clamps the output
module rc_high_pass_filter_serial
    import discrete_audio_pkg::*;
#(
    parameter int SAMPLE_RATE  = 48000,
    parameter int R            = 47000,
    parameter int C_35_SHIFTED = 1615
) (
    input  logic    clk,
    input  logic    I_RST,
    input  logic    audio_clk_en,
    input  sample_t in,
    output sample_t out,
    output logic    out_valid,
    output logic    busy
);

    localparam logic [15:0] ALPHA   = calc_alpha(SAMPLE_RATE, R, C_35_SHIFTED);
    localparam sum_t        SAT_MAX = 18'sd32767;
    localparam sum_t        SAT_MIN = -18'sd32768;

    filt_state_t        state;
    sample_t            x_prev;
    sum_t               mcand;
    sum_t               shifted;
    sample_t            y_next;
    logic               start;
    logic               mult_done;
    logic signed [33:0] acc;

    assign start   = (state == ST_IDLE) && audio_clk_en;
    assign mcand   = {{2{out[15]}}, out} + {{2{in[15]}}, in} - {{2{x_prev[15]}}, x_prev};
    assign shifted = acc[33:16];

`ifdef RC_HPF_SATURATE_EN
    always_comb begin
        y_next = shifted[15:0];
        if (shifted > SAT_MAX)
            y_next = 16'sh7fff;
        else if (shifted < SAT_MIN)
            y_next = 16'sh8000;
    end
`else
    assign y_next = shifted[15:0];
`endif

    serial_mult_16 u_mult (
        .clk     (clk),
        .I_RST   (I_RST),
        .start   (start),
        .mcand   (mcand),
        .mplier  (ALPHA),
        .done    (mult_done),
        .product (acc)
    );

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state     <= ST_IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            x_prev    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (audio_clk_en) begin
                        x_prev <= in;
                        busy   <= 1'b1;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mult_done)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    out       <= y_next;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
